gpio_irq: RTL and testbench

Parametrised successor to the 8-bit LED GPIO peripheral on the picorv32 native memory bus. Provides WIDTH bidirectional pins with per-pin direction, atomic set/clear/toggle, synchronised inputs, and per-pin rising/falling edge capture into a sticky status register that drives a level interrupt. The block sits beside `memory` as a bus slave selected by one `address_decoder` enable line. Its `irq` output feeds one bit of the CPU `irq` vector.

---
 rtl/gpio_irq_pkg.sv | 35 +++
 rtl/gpio_sync.sv | 40 ++++
 rtl/gpio_irq.sv | 156 +++++++++++++++
 tb/tb_gpio_irq.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the gpio_irq peripheral: register map, decode width,
// bus handshake states and the byte-strobe expansion helper.
package gpio_irq_pkg;

    // Number of word-address bits decoded from mem_addr[5:2]
    localparam int unsigned GPIO_DECODE_W = 4;

    // Register word offsets
    localparam logic [GPIO_DECODE_W-1:0] GPIO_OUT     = 4'd0;
    localparam logic [GPIO_DECODE_W-1:0] GPIO_DIR     = 4'd1;
    localparam logic [GPIO_DECODE_W-1:0] GPIO_IN      = 4'd2;
    localparam logic [GPIO_DECODE_W-1:0] GPIO_SET     = 4'd3;
    localparam logic [GPIO_DECODE_W-1:0] GPIO_CLR     = 4'd4;
    localparam logic [GPIO_DECODE_W-1:0] GPIO_TGL     = 4'd5;
    localparam logic [GPIO_DECODE_W-1:0] GPIO_RISE_EN = 4'd6;
    localparam logic [GPIO_DECODE_W-1:0] GPIO_FALL_EN = 4'd7;
    localparam logic [GPIO_DECODE_W-1:0] GPIO_STATUS  = 4'd8;

    // Bus slave handshake: idle, or presenting the one-cycle acknowledge
    typedef enum logic {
        BUS_IDLE,
        BUS_ACK
    } bus_state_t;

    // Expand the 4 byte strobes into a 32-bit bit mask
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchroniser with a one-cycle delayed copy of the
// synchronised value, producing per-pin rising/falling edge strobes.
module gpio_sync
    import gpio_irq_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_s,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    // Shift pins through the synchroniser chain and remember the last stage
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                r_stage[k] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_stage[0] <= i_pins;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            r_prev <= r_stage[SYNC_STAGES-1];
        end
    end

    assign o_s    = r_stage[SYNC_STAGES-1];
    assign o_rise = o_s & ~r_prev;
    assign o_fall = ~o_s & r_prev;

endmodule

// File: rtl/gpio_irq.sv
// GPIO peripheral on the picorv32 native bus: per-pin direction, atomic
// set/clear/toggle, synchronised inputs and sticky edge capture driving a
// level interrupt. Outputs are zero when not addressed so they OR-combine.
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    bus_state_t               r_state;
    logic                     r_ready;
    logic [31:0]              r_rdata;
    logic [WIDTH-1:0]         r_out;
    logic [WIDTH-1:0]         r_dir;
    logic [WIDTH-1:0]         r_rise_en;
    logic [WIDTH-1:0]         r_fall_en;
    logic [WIDTH-1:0]         r_status;

    logic [WIDTH-1:0]         w_s;
    logic [WIDTH-1:0]         w_rise;
    logic [WIDTH-1:0]         w_fall;
    logic [GPIO_DECODE_W-1:0] w_off;
    logic                     w_req;
    logic                     w_is_read;
    logic                     w_wr;
    logic [31:0]              w_mask32;
    logic [WIDTH-1:0]         w_mask;
    logic [WIDTH-1:0]         w_wd;
    logic [WIDTH-1:0]         w_clr;
    logic [31:0]              w_rd_val;
    logic                     w_unused;

    gpio_sync #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (clk),
        .i_reset(reset),
        .i_pins (gpio_in),
        .o_s    (w_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Request accepted only while idle, so an ack is never followed by another
    assign w_off     = mem_addr[5:2];
    assign w_req     = mem_valid & enable & (r_state == BUS_IDLE);
    assign w_is_read = ~mem_instr & (mem_wstrb == 4'b0000);
    assign w_wr      = w_req & ~mem_instr & (|mem_wstrb);
    assign w_mask32  = strb_to_mask(mem_wstrb);
    assign w_mask    = w_mask32[WIDTH-1:0];
    assign w_wd      = mem_wdata[WIDTH-1:0] & w_mask;
    assign w_clr     = (w_wr && (w_off == GPIO_STATUS)) ? w_wd : '0;
    assign w_unused  = ^{mem_addr[31:6], mem_addr[1:0], mem_wdata, w_mask32};

    // Read mux: unmapped, write-only and instruction accesses return zero
    always_comb begin
        w_rd_val = '0;
        if (w_is_read) begin
            case (w_off)
                GPIO_OUT:     w_rd_val[WIDTH-1:0] = r_out;
                GPIO_DIR:     w_rd_val[WIDTH-1:0] = r_dir;
                GPIO_IN:      w_rd_val[WIDTH-1:0] = w_s;
                GPIO_RISE_EN: w_rd_val[WIDTH-1:0] = r_rise_en;
                GPIO_FALL_EN: w_rd_val[WIDTH-1:0] = r_fall_en;
                GPIO_STATUS:  w_rd_val[WIDTH-1:0] = r_status;
                default:      w_rd_val = '0;
            endcase
        end
    end

    // Bus handshake FSM with registered ready and read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BUS_IDLE;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                BUS_IDLE: begin
                    if (w_req) begin
                        r_state <= BUS_ACK;
                        r_ready <= 1'b1;
                        r_rdata <= w_rd_val;
                    end else begin
                        r_ready <= 1'b0;
                        r_rdata <= '0;
                    end
                end
                BUS_ACK: begin
                    r_state <= BUS_IDLE;
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= BUS_IDLE;
                    r_ready <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    // Writable control registers, byte-strobe masked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
        end else if (w_wr) begin
            case (w_off)
                GPIO_OUT:     r_out     <= (r_out & ~w_mask) | w_wd;
                GPIO_DIR:     r_dir     <= (r_dir & ~w_mask) | w_wd;
                GPIO_SET:     r_out     <= r_out | w_wd;
                GPIO_CLR:     r_out     <= r_out & ~w_wd;
                GPIO_TGL:     r_out     <= r_out ^ w_wd;
                GPIO_RISE_EN: r_rise_en <= (r_rise_en & ~w_mask) | w_wd;
                GPIO_FALL_EN: r_fall_en <= (r_fall_en & ~w_mask) | w_wd;
                default:      ;
            endcase
        end
    end

    // Sticky edge status: a new enabled edge overrides a same-cycle W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign gpio_out  = r_out;
    assign gpio_oe   = r_dir;
    assign irq       = |(r_status & (r_rise_en | r_fall_en));

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq: an 8-pin and a 32-pin instance share one bus. A
// behavioural model predicts every response into per-instance queues; a
// monitor compares DUT outputs against the model every cycle.
module tb_gpio_irq;
    import gpio_irq_pkg::*;

    localparam int SS = 2;

    logic        clk;
    logic        reset;
    logic        en8, en32;
    logic        valid, instr;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata;
    logic [7:0]  gin8;
    logic [31:0] gin32;

    logic        rdy8, rdy32, irq8, irq32;
    logic [31:0] rd8, rd32;
    logic [7:0]  out8, oe8;
    logic [31:0] out32, oe32;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ack_cyc = 0;

    gpio_irq #(.WIDTH(8), .SYNC_STAGES(SS)) u_dut8 (
        .clk(clk), .reset(reset), .enable(en8), .mem_valid(valid),
        .mem_instr(instr), .mem_wstrb(wstrb), .mem_addr(addr),
        .mem_wdata(wdata), .mem_ready(rdy8), .mem_rdata(rd8),
        .gpio_in(gin8), .gpio_out(out8), .gpio_oe(oe8), .irq(irq8)
    );

    gpio_irq #(.WIDTH(32), .SYNC_STAGES(SS)) u_dut32 (
        .clk(clk), .reset(reset), .enable(en32), .mem_valid(valid),
        .mem_instr(instr), .mem_wstrb(wstrb), .mem_addr(addr),
        .mem_wdata(wdata), .mem_ready(rdy32), .mem_rdata(rd32),
        .gpio_in(gin32), .gpio_out(out32), .gpio_oe(oe32), .irq(irq32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] m_out [2];
    logic [31:0] m_dir [2];
    logic [31:0] m_ren [2];
    logic [31:0] m_fen [2];
    logic [31:0] m_st  [2];
    logic        m_rdy [2];
    logic [31:0] hist  [2][SS+1];   // pin samples, newest first
    logic [31:0] q8[$];
    logic [31:0] q32[$];

    function automatic logic [31:0] wmask(input int d);
        return (d == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    endfunction

    initial begin : model
        logic [31:0] pins, s, p, ed, clr, rdv;
        logic        acc;
        logic [3:0]  off;
        logic [7:0]  b;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int d = 0; d < 2; d++) begin
                    m_out[d] = '0; m_dir[d] = '0; m_ren[d] = '0;
                    m_fen[d] = '0; m_st[d] = '0;  m_rdy[d] = 1'b0;
                    for (int k = 0; k <= SS; k++) hist[d][k] = '0;
                end
                q8.delete();
                q32.delete();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    pins = (d == 0) ? {24'b0, gin8} : gin32;
                    s    = hist[d][SS-1];          // value visible in IN now
                    p    = hist[d][SS];
                    ed   = (s & ~p & m_ren[d]) | (~s & p & m_fen[d]);
                    acc  = valid && ((d == 0) ? en8 : en32) && !m_rdy[d];
                    clr  = '0;
                    off  = addr[5:2];
                    if (acc) begin
                        rdv = '0;
                        if (wstrb == 4'b0 && !instr) begin
                            case (off)
                                GPIO_OUT:     rdv = m_out[d];
                                GPIO_DIR:     rdv = m_dir[d];
                                GPIO_IN:      rdv = s;
                                GPIO_RISE_EN: rdv = m_ren[d];
                                GPIO_FALL_EN: rdv = m_fen[d];
                                GPIO_STATUS:  rdv = m_st[d];
                                default:      rdv = '0;
                            endcase
                        end
                        if (d == 0) q8.push_back(rdv);
                        else        q32.push_back(rdv);
                        if (!instr) begin
                            for (int k = 0; k < 4; k++) begin
                                if (wstrb[k]) begin
                                    b = wdata[8*k +: 8];
                                    case (off)
                                        GPIO_OUT:     m_out[d][8*k +: 8] = b;
                                        GPIO_DIR:     m_dir[d][8*k +: 8] = b;
                                        GPIO_SET:     m_out[d][8*k +: 8] = m_out[d][8*k +: 8] | b;
                                        GPIO_CLR:     m_out[d][8*k +: 8] = m_out[d][8*k +: 8] & ~b;
                                        GPIO_TGL:     m_out[d][8*k +: 8] = m_out[d][8*k +: 8] ^ b;
                                        GPIO_RISE_EN: m_ren[d][8*k +: 8] = b;
                                        GPIO_FALL_EN: m_fen[d][8*k +: 8] = b;
                                        GPIO_STATUS:  clr[8*k +: 8] = b;
                                        default:      ;
                                    endcase
                                end
                            end
                        end
                        m_out[d] = m_out[d] & wmask(d);
                        m_dir[d] = m_dir[d] & wmask(d);
                        m_ren[d] = m_ren[d] & wmask(d);
                        m_fen[d] = m_fen[d] & wmask(d);
                    end
                    m_st[d]  = ((m_st[d] & ~clr) | ed) & wmask(d);
                    m_rdy[d] = acc;
                    for (int k = SS; k > 0; k--) hist[d][k] = hist[d][k-1];
                    hist[d][0] = pins & wmask(d);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int d, input logic rdy, input logic [31:0] rdv,
                             input logic [31:0] o, input logic [31:0] oe, input logic iq);
        logic [31:0] e;
        chk($sformatf("mon_ready%0d", d), {31'b0, rdy}, {31'b0, m_rdy[d]});
        if (rdy === 1'b1) begin
            n_chk++;
            if ((d == 0 && q8.size() == 0) || (d == 1 && q32.size() == 0)) begin
                n_fail++;
                $display("FAIL mon_unexpected_ack%0d: got ack, expected none", d);
            end else begin
                e = (d == 0) ? q8.pop_front() : q32.pop_front();
                chk($sformatf("mon_rdata%0d", d), rdv, e);
            end
        end else begin
            chk($sformatf("mon_rdata_idle%0d", d), rdv, 32'h0);
        end
        chk($sformatf("mon_gpio_out%0d", d), o, m_out[d]);
        chk($sformatf("mon_gpio_oe%0d", d), oe, m_dir[d]);
        chk($sformatf("mon_irq%0d", d), {31'b0, iq},
            {31'b0, |(m_st[d] & (m_ren[d] | m_fen[d]))});
    endtask

    initial begin : monitor
        @(posedge clk);
        forever begin
            @(negedge clk);
            check_dut(0, rdy8, rd8, {24'b0, out8}, {24'b0, oe8}, irq8);
            check_dut(1, rdy32, rd32, out32, oe32, irq32);
        end
    end

    // ---------------- stimulus ----------------
    task automatic xfer(input int sel, input logic [3:0] off, input logic [3:0] strb,
                        input logic [31:0] data, input logic ins, input bit hold,
                        output logic [31:0] rdat);
        bit got;
        @(negedge clk);
        valid = 1'b1;
        en8   = (sel == 0);
        en32  = (sel == 1);
        addr  = {26'b0, off, 2'b00};
        wstrb = strb;
        wdata = data;
        instr = ins;
        got   = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (((sel == 0) ? rdy8 : rdy32) === 1'b1) got = 1'b1;
        end
        rdat = (sel == 0) ? rd8 : rd32;
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout: got no ack, expected ack within 6 cycles");
        end
        ack_cyc = cyc;
        if (!hold) begin
            valid = 1'b0; en8 = 1'b0; en32 = 1'b0; wstrb = 4'b0; instr = 1'b0;
        end
    endtask

    initial begin : stim
        logic [31:0] r;
        int prev;
        logic [3:0] off, strb;
        logic ins;
        bit hold;
        int sel;

        reset = 1'b1; valid = 1'b0; en8 = 1'b0; en32 = 1'b0; instr = 1'b0;
        wstrb = 4'b0; addr = '0; wdata = '0; gin8 = '0; gin32 = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", {24'b0, out8}, 32'h0);
        chk("reset_oe", {24'b0, oe8}, 32'h0);
        chk("reset_irq", {31'b0, irq8}, 32'h0);
        chk("reset_ready", {31'b0, rdy8}, 32'h0);
        chk("reset_rdata", rd8, 32'h0);
        reset = 1'b0;

        // Atomic output operations, back-to-back with valid held
        xfer(0, GPIO_OUT, 4'hF, 32'h0000_00A5, 1'b0, 1'b1, r);
        chk("out_write", {24'b0, out8}, 32'hA5);
        prev = ack_cyc;
        xfer(0, GPIO_SET, 4'hF, 32'h0000_000F, 1'b0, 1'b1, r);
        chk("out_set", {24'b0, out8}, 32'hAF);
        chk("ack_spacing_set", 32'(ack_cyc - prev), 32'd2);
        prev = ack_cyc;
        xfer(0, GPIO_CLR, 4'hF, 32'h0000_0081, 1'b0, 1'b1, r);
        chk("out_clr", {24'b0, out8}, 32'h2E);
        chk("ack_spacing_clr", 32'(ack_cyc - prev), 32'd2);
        prev = ack_cyc;
        xfer(0, GPIO_TGL, 4'hF, 32'h0000_00FF, 1'b0, 1'b0, r);
        chk("out_tgl", {24'b0, out8}, 32'hD1);
        chk("ack_spacing_tgl", 32'(ack_cyc - prev), 32'd2);
        xfer(0, GPIO_TGL, 4'hF, 32'h0000_00FF, 1'b0, 1'b0, r);
        chk("out_tgl_again", {24'b0, out8}, 32'h2E);
        xfer(0, GPIO_OUT, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("read_out", r, 32'h2E);
        xfer(0, GPIO_TGL, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("read_tgl_zero", r, 32'h0);

        // Direction and upper-bit masking on the 8-pin instance
        xfer(0, GPIO_DIR, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0, r);
        chk("oe8_all", {24'b0, oe8}, 32'hFF);
        xfer(0, GPIO_DIR, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("read_dir8_masked", r, 32'h0000_00FF);

        // Byte strobes on the 32-pin instance
        xfer(1, GPIO_DIR, 4'b0010, 32'hFFFF_FFFF, 1'b0, 1'b0, r);
        chk("oe32_strobe", oe32, 32'h0000_FF00);
        xfer(1, 4'd12, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("read_off12", r, 32'h0);
        xfer(1, GPIO_SET, 4'b0100, 32'hFFFF_FFFF, 1'b0, 1'b0, r);
        chk("out32_set_strobe", out32, 32'h00FF_0000);

        // Rising-edge capture latency
        xfer(0, GPIO_RISE_EN, 4'hF, 32'h01, 1'b0, 1'b0, r);
        @(negedge clk);
        gin8[0] = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("irq_before_capture", {31'b0, irq8}, 32'h0);
        @(posedge clk); #1;
        chk("irq_after_capture", {31'b0, irq8}, 32'h1);
        xfer(0, GPIO_IN, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("read_in", r, 32'h01);
        xfer(0, GPIO_STATUS, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("read_status_rise", r, 32'h01);
        xfer(0, GPIO_STATUS, 4'hF, 32'h01, 1'b0, 1'b0, r);
        chk("irq_w1c", {31'b0, irq8}, 32'h0);

        // Clear/edge collision on pin 3
        xfer(0, GPIO_FALL_EN, 4'hF, 32'h08, 1'b0, 1'b0, r);
        gin8[3] = 1'b1; repeat (5) @(negedge clk);
        gin8[3] = 1'b0; repeat (5) @(negedge clk);
        chk("irq_fall", {31'b0, irq8}, 32'h1);
        xfer(0, GPIO_FALL_EN, 4'hF, 32'h00, 1'b0, 1'b0, r);
        chk("irq_masked", {31'b0, irq8}, 32'h0);
        xfer(0, GPIO_STATUS, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("status_kept_masked", r, 32'h08);
        xfer(0, GPIO_FALL_EN, 4'hF, 32'h08, 1'b0, 1'b0, r);
        gin8[3] = 1'b1; repeat (5) @(negedge clk);
        gin8[3] = 1'b0;
        @(negedge clk);
        xfer(0, GPIO_STATUS, 4'hF, 32'h08, 1'b0, 1'b0, r);
        chk("irq_collision", {31'b0, irq8}, 32'h1);
        xfer(0, GPIO_STATUS, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("status_collision", r, 32'h08);
        xfer(0, GPIO_STATUS, 4'hF, 32'h08, 1'b0, 1'b0, r);
        chk("irq_cleared", {31'b0, irq8}, 32'h0);

        // Instruction fetch returns zero
        xfer(0, GPIO_DIR, 4'h0, 32'h0, 1'b1, 1'b0, r);
        chk("instr_read", r, 32'h0);

        // Reset in the middle of an accepted read
        @(negedge clk);
        valid = 1'b1; en8 = 1'b1; addr = {26'b0, GPIO_DIR, 2'b00}; wstrb = 4'h0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midreset_ready", {31'b0, rdy8}, 32'h0);
        chk("midreset_rdata", rd8, 32'h0);
        chk("midreset_out", {24'b0, out8}, 32'h0);
        chk("midreset_oe", {24'b0, oe8}, 32'h0);
        valid = 1'b0; en8 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        xfer(0, GPIO_DIR, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("dir_after_reset", r, 32'h0);

        // Edges before enabling capture are not recorded
        gin8[1] = 1'b1; repeat (4) @(negedge clk);
        gin8[1] = 1'b0; repeat (4) @(negedge clk);
        xfer(0, GPIO_RISE_EN, 4'hF, 32'h02, 1'b0, 1'b0, r);
        xfer(0, GPIO_STATUS, 4'h0, 32'h0, 1'b0, 1'b0, r);
        chk("no_early_capture", r, 32'h0);

        // Bus sharing: valid without chip select
        @(negedge clk);
        valid = 1'b1; en8 = 1'b0; en32 = 1'b0; addr = {26'b0, GPIO_OUT, 2'b00};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("share_ready", {30'b0, rdy8, rdy32}, 32'h0);
            chk("share_rdata", rd8 | rd32, 32'h0);
        end
        valid = 1'b0;

        // Randomised traffic across both instances
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) gin8 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) gin32 = $urandom;
            sel  = int'($urandom_range(0, 1));
            off  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                               : 4'($urandom_range(0, 8));
            strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            ins  = (strb == 4'h0) && ($urandom_range(0, 9) == 0);
            hold = ($urandom_range(0, 2) == 0);
            xfer(sel, off, strb, $urandom, ins, hold, r);
            if (!hold && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        valid = 1'b0; en8 = 1'b0; en32 = 1'b0; wstrb = 4'h0;
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(q8.size() + q32.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
